mem_port_arbiter: RTL and testbench

Arbitrates the instruction-cache and data-cache refill/write-back requests onto the single shared main-memory port. It sits between the two caches' memory-side interfaces and the memory model. A three-state FSM grants one requester at a time, holds the grant until memory completes, and returns a registered response. Simultaneous requests are resolved round-robin, so neither stream starves.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the memory port arbiter
// Contents: FSM state codes, grant side codes, default address/data widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic G_I = 1'b0;
    localparam logic G_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_RESP = S_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin select
// Ports:
//   req_i, req_d  : request levels from the I-side and D-side
//   last_grant    : side granted most recently (G_I / G_D)
//   gnt_valid     : at least one side is requesting
//   gnt_sel       : side to grant (meaningful only when gnt_valid)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_sel
);

    always_comb begin
        gnt_valid = req_i | req_d;
        if (req_i && req_d) begin
            // Tie: the side that did not win last time goes first.
            gnt_sel = ~last_grant;
        end else if (req_d) begin
            gnt_sel = G_D;
        end else begin
            gnt_sel = G_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one main-memory port between I-cache and D-cache
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata  : I-cache request (level, held until i_ready)
//   i_ready/i_rdata                : I-cache one-cycle completion and read line
//   d_*                            : same set for the D-cache
//   mem_read/mem_write/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ready            : memory read line and one-cycle completion
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       r_grant_sel;
    logic       w_req_i;
    logic       w_req_d;
    logic       w_gnt_valid;
    logic       w_gnt_sel;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    rr_pick2 u_pick (
        .req_i      (w_req_i),
        .req_d      (w_req_d),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_sel    (w_gnt_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_valid) w_state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ready)   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= G_I;
            r_grant_sel  <= G_I;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Ready pulses are only ever set for the single RESP cycle.
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant_sel  <= w_gnt_sel;
                        r_last_grant <= w_gnt_sel;
                        // A side asserting both strobes is treated as a write.
                        if (w_gnt_sel == G_D) begin
                            mem_write <= d_write;
                            mem_read  <= d_read & ~d_write;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_write <= i_write;
                            mem_read  <= i_read & ~i_write;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (r_grant_sel == G_D) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end
                    end
                end
                ST_RESP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          side;
        logic          chk;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stb_start = 0;
    int   mem_lat = 3;
    int   late_req = 0;
    logic i_busy = 1'b0, d_busy = 1'b0;

    req_t iq[$];
    req_t dq[$];
    req_t exp_mem[$];
    rsp_t exp_rsp[$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {16{8'hA5}};
        return {4{4'hB, a}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic exp_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
        exp_mem.push_back(r);
    endtask

    task automatic exp_resp(input logic side, input logic c, input logic [DW-1:0] data);
        rsp_t e;
        e.side = side; e.chk = c; e.rdata = data;
        exp_rsp.push_back(e);
    endtask

    task automatic cache_req(input logic side, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
        if (side == G_D) dq.push_back(r);
        else iq.push_back(r);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (iq.size() != 0 || dq.size() != 0 || exp_mem.size() != 0 ||
               exp_rsp.size() != 0 || i_busy || d_busy) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s pending_mem=%0d pending_rsp=%0d", nm, exp_mem.size(), exp_rsp.size());
                iq.delete(); dq.delete(); exp_mem.delete(); exp_rsp.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    // Memory model: responds mem_lat cycles after the strobe first appears.
    initial begin
        int cnt;
        int late_done;
        cnt = 0;
        late_done = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (rst) begin
                cnt = 0;
            end else if (late_req != late_done) begin
                late_done++;
                mem_ready = 1'b1;
                mem_rdata = {4{32'hDEADBEEF}};
            end else if (mem_read | mem_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_line(mem_addr);
                end
            end
        end
    end

    // I-cache model: holds a request until i_ready, then presents the next.
    initial begin
        req_t r;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                i_busy = 1'b0; i_read = 1'b0; i_write = 1'b0;
            end else begin
                if (i_ready) i_busy = 1'b0;
                if (!i_busy) begin
                    if (iq.size() > 0) begin
                        r = iq.pop_front();
                        i_read = r.rd; i_write = r.wr; i_addr = r.addr; i_wdata = r.wdata;
                        i_busy = 1'b1;
                    end else begin
                        i_read = 1'b0; i_write = 1'b0;
                    end
                end
            end
        end
    end

    // D-cache model.
    initial begin
        req_t r;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                d_busy = 1'b0; d_read = 1'b0; d_write = 1'b0;
            end else begin
                if (d_ready) d_busy = 1'b0;
                if (!d_busy) begin
                    if (dq.size() > 0) begin
                        r = dq.pop_front();
                        d_read = r.rd; d_write = r.wr; d_addr = r.addr; d_wdata = r.wdata;
                        d_busy = 1'b1;
                    end else begin
                        d_read = 1'b0; d_write = 1'b0;
                    end
                end
            end
        end
    end

    // Memory-side monitor.
    initial begin
        logic prev_stb;
        logic prev_rdy;
        req_t cur;
        prev_stb = 1'b0;
        prev_rdy = 1'b0;
        cur.rd = 1'b0; cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if ((mem_read | mem_write) && !prev_stb) begin
                stb_start = cyc;
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req addr=%h", mem_addr);
                end else begin
                    cur = exp_mem.pop_front();
                    chk1("mem_read", mem_read, cur.rd);
                    chk1("mem_write", mem_write, cur.wr);
                    chk("mem_addr", DW'(mem_addr), DW'(cur.addr));
                    chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else if (mem_read | mem_write) begin
                chk("mem_addr_stable", DW'(mem_addr), DW'(cur.addr));
                chk("mem_wdata_stable", mem_wdata, cur.wdata);
            end else if (prev_stb) begin
                chk1("strobe_drop_cause", prev_rdy | rst, 1'b1);
            end
            prev_stb = mem_read | mem_write;
            prev_rdy = mem_ready;
        end
    end

    // Cache-side response monitor.
    initial begin
        rsp_t e;
        logic [DW-1:0] last_i;
        logic [DW-1:0] last_d;
        last_i = '0;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (i_ready | d_ready) begin
                chk1("single_ready", i_ready & d_ready, 1'b0);
                chk_i("ready_latency", cyc - stb_start, mem_lat);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready i_ready=%b d_ready=%b", i_ready, d_ready);
                end else begin
                    e = exp_rsp.pop_front();
                    chk1("ready_side", d_ready, e.side);
                    if (e.chk) chk("rdata", d_ready ? d_rdata : i_rdata, e.rdata);
                end
                if (d_ready) begin
                    chk("i_rdata_kept", i_rdata, last_i);
                    last_d = d_rdata;
                end else begin
                    chk("d_rdata_kept", d_rdata, last_d);
                    last_i = i_rdata;
                end
            end
            if (rst) begin
                last_i = '0;
                last_d = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        #1 rst = 1'b0;

        // Single I read, memory answers on the third strobe cycle.
        mem_lat = 3;
        exp_req(1'b1, 1'b0, 28'h0000010, '0);
        exp_resp(G_I, 1'b1, {16{8'hA5}});
        cache_req(G_I, 1'b1, 1'b0, 28'h0000010, '0);
        wait_done("single_i");

        // Tie straight after reset: D first, then I.
        do_reset();
        mem_lat = 2;
        exp_req(1'b1, 1'b0, 28'h0000030, '0);
        exp_req(1'b1, 1'b0, 28'h0000020, '0);
        exp_resp(G_D, 1'b1, mem_line(28'h0000030));
        exp_resp(G_I, 1'b1, mem_line(28'h0000020));
        cache_req(G_I, 1'b1, 1'b0, 28'h0000020, '0);
        cache_req(G_D, 1'b1, 1'b0, 28'h0000030, '0);
        wait_done("tie");

        // Sustained contention: last grant was I, so D leads and they alternate.
        for (int k = 0; k < 4; k++) begin
            exp_req(1'b1, 1'b0, 28'h0000200 + AW'(k), '0);
            exp_resp(G_D, 1'b1, mem_line(28'h0000200 + AW'(k)));
            exp_req(1'b1, 1'b0, 28'h0000100 + AW'(k), '0);
            exp_resp(G_I, 1'b1, mem_line(28'h0000100 + AW'(k)));
        end
        for (int k = 0; k < 4; k++) begin
            cache_req(G_I, 1'b1, 1'b0, 28'h0000100 + AW'(k), '0);
            cache_req(G_D, 1'b1, 1'b0, 28'h0000200 + AW'(k), '0);
        end
        wait_done("contention");

        // D write-back then refill of the same line.
        mem_lat = 3;
        exp_req(1'b0, 1'b1, 28'h0000040, 128'h1234);
        exp_req(1'b1, 1'b0, 28'h0000040, '0);
        exp_resp(G_D, 1'b0, '0);
        exp_resp(G_D, 1'b1, mem_line(28'h0000040));
        cache_req(G_D, 1'b0, 1'b1, 28'h0000040, 128'h1234);
        cache_req(G_D, 1'b1, 1'b0, 28'h0000040, '0);
        wait_done("d_wr_rd");

        // Both strobes from D: write wins.
        exp_req(1'b0, 1'b1, 28'h0000050, 128'h55);
        exp_resp(G_D, 1'b0, '0);
        cache_req(G_D, 1'b1, 1'b1, 28'h0000050, 128'h55);
        wait_done("both_strobes");

        // Reset while BUSY, then a stray mem_ready.
        mem_lat = 20;
        exp_req(1'b1, 1'b0, 28'h0000060, '0);
        cache_req(G_I, 1'b1, 1'b0, 28'h0000060, '0);
        n = 0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("busy_read_seen", mem_read, 1'b1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("reset_drops_read", mem_read, 1'b0);
        chk1("reset_no_i_ready", i_ready, 1'b0);
        #1 rst = 1'b0;
        late_req++;
        repeat (5) @(negedge clk);
        chk1("late_ready_no_read", mem_read, 1'b0);
        chk1("late_ready_no_i_ready", i_ready, 1'b0);
        chk("late_ready_i_rdata", i_rdata, '0);

        mem_lat = 2;
        exp_req(1'b1, 1'b0, 28'h0000070, '0);
        exp_resp(G_I, 1'b1, mem_line(28'h0000070));
        cache_req(G_I, 1'b1, 1'b0, 28'h0000070, '0);
        wait_done("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
